mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath.
- Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath's 2:1 ALU-source mux, 4:1 5-bit register-destination mux and 8:1 32-bit write-back mux, plus all write enables and ALU/NPC/extend opcodes.
- Replaces the single-cycle combinational controller; keeps a retired-instruction counter.

---
 rtl/mc_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath.
// Walks one instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath's enables, mux selects and ALU/NPC/extend opcodes.
// Keeps a retired-instruction counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   opcode     IR[31:26], stable from DECODE until retire
//   funct      IR[5:0], same stability as opcode
//   zero       ALU result == 0, valid in EXEC
//   pc_write   PC load enable
//   ir_write   IR load enable
//   reg_write  GRF write enable
//   mem_write  DM write enable
//   alu_src    ALU B select: 0 = rt, 1 = extended imm
//   reg_dst    dest select: 00 = rt, 01 = rd, 10 = $31
//   mem_to_reg WB select: 000 = ALU, 001 = DM, 010 = PC+4, 011 = {imm,16'b0}
//   alu_op     000 = add, 001 = sub, 010 = or
//   ext_op     0 = zero-extend, 1 = sign-extend
//   npc_op     00 = PC+4, 01 = branch, 10 = jal target, 11 = rs
//   state      FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4
//   retire     high in the final cycle of each instruction
//   instr_cnt  retired-instruction count (wraps)
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_src,
  output logic [1:0]       reg_dst,
  output logic [2:0]       mem_to_reg,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic [1:0]       npc_op,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
    C_LW, C_SW, C_BEQ, C_JAL, C_BNEZALC
  } cls_t;

  // One bundle for everything the FSM drives, so reset gating is one line.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic [2:0] alu_op;
    logic       ext_op;
    logic [1:0] npc_op;
    logic       retire;
  } ctrl_t;

  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [2:0] WB_ALU = 3'b000, WB_DM = 3'b001, WB_PC4 = 3'b010, WB_LUI = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_OR = 3'b010;
  localparam logic [1:0] NPC_SEQ = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_RS = 2'b11;

  state_t cur, nxt;
  cls_t   cls;
  ctrl_t  c;

  // instruction class decode
  always_comb begin
    cls = C_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: cls = C_ADDU;
          6'b100011: cls = C_SUBU;
          6'b001000: cls = C_JR;
          default:   cls = C_ILL;
        endcase
      end
      6'b001101: cls = C_ORI;
      6'b001111: cls = C_LUI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b000011: cls = C_JAL;
      6'b011000: cls = C_BNEZALC;
      default:   cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // next state + raw control (before reset gating)
  always_comb begin
    nxt = S_FETCH;
    c   = '0;
    case (cur)
      S_FETCH: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.npc_op   = NPC_SEQ;
        nxt        = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_JAL: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RD_RA;
            c.mem_to_reg = WB_PC4;
            c.pc_write   = 1'b1;
            c.npc_op     = NPC_J;
            c.retire     = 1'b1;
            nxt          = S_FETCH;
          end
          C_JR: begin
            c.pc_write = 1'b1;
            c.npc_op   = NPC_RS;
            c.retire   = 1'b1;
            nxt        = S_FETCH;
          end
          C_ILL: begin
            c.retire = 1'b1;     // retired as a nop
            nxt      = S_FETCH;
          end
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_ADDU: begin
            c.alu_op = OP_ADD;
            nxt      = S_WB;
          end
          C_SUBU: begin
            c.alu_op = OP_SUB;
            nxt      = S_WB;
          end
          C_ORI: begin
            c.alu_src = 1'b1;
            c.ext_op  = 1'b0;
            c.alu_op  = OP_OR;
            nxt       = S_WB;
          end
          C_LUI: nxt = S_WB;
          C_LW, C_SW: begin
            c.alu_src = 1'b1;
            c.ext_op  = 1'b1;
            c.alu_op  = OP_ADD;
            nxt       = S_MEM;
          end
          C_BEQ: begin
            c.alu_op   = OP_SUB;
            c.npc_op   = NPC_BR;
            c.pc_write = zero;
            c.retire   = 1'b1;
            nxt        = S_FETCH;
          end
          C_BNEZALC: begin
            // rt - $0: branch and link only when rt != 0
            c.alu_op = OP_SUB;
            c.npc_op = NPC_BR;
            if (!zero) begin
              c.pc_write   = 1'b1;
              c.reg_write  = 1'b1;
              c.reg_dst    = RD_RA;
              c.mem_to_reg = WB_PC4;
            end
            c.retire = 1'b1;
            nxt      = S_FETCH;
          end
          default: nxt = S_FETCH;  // decode filters the rest; never reached
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) begin
          c.mem_write = 1'b1;
          c.retire    = 1'b1;
          nxt         = S_FETCH;
        end else if (cls == C_LW) begin
          nxt = S_WB;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
        nxt         = S_FETCH;
        case (cls)
          C_ADDU, C_SUBU: begin c.reg_dst = RD_RD; c.mem_to_reg = WB_ALU; end
          C_ORI:          begin c.reg_dst = RD_RT; c.mem_to_reg = WB_ALU; end
          C_LUI:          begin c.reg_dst = RD_RT; c.mem_to_reg = WB_LUI; end
          C_LW:           begin c.reg_dst = RD_RT; c.mem_to_reg = WB_DM;  end
          default: begin
            c.reg_write = 1'b0;   // no class reaches WB otherwise
            c.retire    = 1'b0;
          end
        endcase
      end
      default: begin
        c   = '0;                 // encodings 5..7: recover quietly
        nxt = S_FETCH;
      end
    endcase
  end

  // Reset forces every output low combinationally, so a write in flight
  // drops in the same cycle reset falls.
  ctrl_t co;
  assign co = reset ? c : '0;

  assign pc_write   = co.pc_write;
  assign ir_write   = co.ir_write;
  assign reg_write  = co.reg_write;
  assign mem_write  = co.mem_write;
  assign alu_src    = co.alu_src;
  assign reg_dst    = co.reg_dst;
  assign mem_to_reg = co.mem_to_reg;
  assign alu_op     = co.alu_op;
  assign ext_op     = co.ext_op;
  assign npc_op     = co.npc_op;
  assign retire     = co.retire;
  assign state      = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       instr_cnt <= '0;
    else if (c.retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. Expected per-cycle outputs are pushed to a
// scoreboard queue as each instruction is set up, then popped and compared
// one cycle at a time. A field of -1 is not checked.
module tb_mc_ctrl;
  localparam int CNT_W = 4;   // small so the wrap is reachable

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = '0, funct = '0;
  logic             zero = 1'b0;
  logic             pc_write, ir_write, reg_write, mem_write, alu_src, ext_op, retire;
  logic [1:0]       reg_dst, npc_op;
  logic [2:0]       mem_to_reg, alu_op, state;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .ext_op(ext_op),
    .npc_op(npc_op), .state(state), .retire(retire), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int st, pcw, irw, rw, mw, ret, cnt, asrc, rdst, m2r, aop, ext, npc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_m  = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input int exp);
    if (exp < 0) return;
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, act, exp);
    end
  endtask

  task automatic push(input string tag, input int st, pcw, irw, rw, mw, ret,
                      input int asrc, rdst, m2r, aop, ext, npc);
    exp_t e;
    e.tag = tag; e.st = st; e.pcw = pcw; e.irw = irw; e.rw = rw; e.mw = mw;
    e.ret = ret; e.cnt = cnt_m; e.asrc = asrc; e.rdst = rdst; e.m2r = m2r;
    e.aop = aop; e.ext = ext; e.npc = npc;
    sbq.push_back(e);
    if (ret == 1) cnt_m = (cnt_m + 1) % (1 << CNT_W);
  endtask

  task automatic fetch(input string tag);
    push({tag, "/F"}, 0, 1, 1, 0, 0, 0, -1, -1, -1, -1, -1, 0);
  endtask

  task automatic decode_go(input string tag);
    push({tag, "/D"}, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
  endtask

  task automatic set(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
  endtask

  // Pops every queued expectation, one per clock, sampling 1 ns after the
  // falling edge where inputs were driven. Returns on a falling edge.
  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      #1;
      chk(e.tag, "state",      32'(state),      e.st);
      chk(e.tag, "pc_write",   32'(pc_write),   e.pcw);
      chk(e.tag, "ir_write",   32'(ir_write),   e.irw);
      chk(e.tag, "reg_write",  32'(reg_write),  e.rw);
      chk(e.tag, "mem_write",  32'(mem_write),  e.mw);
      chk(e.tag, "retire",     32'(retire),     e.ret);
      chk(e.tag, "instr_cnt",  32'(instr_cnt),  e.cnt);
      chk(e.tag, "alu_src",    32'(alu_src),    e.asrc);
      chk(e.tag, "reg_dst",    32'(reg_dst),    e.rdst);
      chk(e.tag, "mem_to_reg", 32'(mem_to_reg), e.m2r);
      chk(e.tag, "alu_op",     32'(alu_op),     e.aop);
      chk(e.tag, "ext_op",     32'(ext_op),     e.ext);
      chk(e.tag, "npc_op",     32'(npc_op),     e.npc);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    // reset held across two edges: FETCH, everything low
    push("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();
    reset = 1'b1;

    // addu: 0,1,2,4
    set(6'b000000, 6'b100001, 1'b0);
    fetch("addu"); decode_go("addu");
    push("addu/E", 2, 0, 0, 0, 0, 0, 0, -1, -1, 0, -1, -1);
    push("addu/W", 4, 0, 0, 1, 0, 1, -1, 1, 0, -1, -1, -1);
    drain();

    // lw: 5 cycles
    set(6'b100011, 6'b000000, 1'b0);
    fetch("lw"); decode_go("lw");
    push("lw/E", 2, 0, 0, 0, 0, 0, 1, -1, -1, 0, 1, -1);
    push("lw/M", 3, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
    push("lw/W", 4, 0, 0, 1, 0, 1, -1, 0, 1, -1, -1, -1);
    drain();

    // sw: MEM writes memory, not the GRF
    set(6'b101011, 6'b000000, 1'b0);
    fetch("sw"); decode_go("sw");
    push("sw/E", 2, 0, 0, 0, 0, 0, 1, -1, -1, 0, 1, -1);
    push("sw/M", 3, 0, 0, 0, 1, 1, -1, -1, -1, -1, -1, -1);
    drain();

    // beq taken, then not taken
    set(6'b000100, 6'b000000, 1'b1);
    fetch("beq1"); decode_go("beq1");
    push("beq1/E", 2, 1, 0, 0, 0, 1, 0, -1, -1, 1, -1, 1);
    drain();
    set(6'b000100, 6'b000000, 1'b0);
    fetch("beq0"); decode_go("beq0");
    push("beq0/E", 2, 0, 0, 0, 0, 1, 0, -1, -1, 1, -1, 1);
    drain();

    // bnezalc: rt != 0 links, rt == 0 does nothing
    set(6'b011000, 6'b000000, 1'b0);
    fetch("bnez0"); decode_go("bnez0");
    push("bnez0/E", 2, 1, 0, 1, 0, 1, -1, 2, 2, 1, -1, 1);
    drain();
    set(6'b011000, 6'b000000, 1'b1);
    fetch("bnez1"); decode_go("bnez1");
    push("bnez1/E", 2, 0, 0, 0, 0, 1, -1, -1, -1, 1, -1, 1);
    drain();

    // jal, jr: retire in DECODE
    set(6'b000011, 6'b000000, 1'b0);
    fetch("jal");
    push("jal/D", 1, 1, 0, 1, 0, 1, -1, 2, 2, -1, -1, 2);
    drain();
    set(6'b000000, 6'b001000, 1'b0);
    fetch("jr");
    push("jr/D", 1, 1, 0, 0, 0, 1, -1, -1, -1, -1, -1, 3);
    drain();

    // ori, lui, subu
    set(6'b001101, 6'b000000, 1'b0);
    fetch("ori"); decode_go("ori");
    push("ori/E", 2, 0, 0, 0, 0, 0, 1, -1, -1, 2, 0, -1);
    push("ori/W", 4, 0, 0, 1, 0, 1, -1, 0, 0, -1, -1, -1);
    drain();
    set(6'b001111, 6'b000000, 1'b0);
    fetch("lui"); decode_go("lui");
    push("lui/E", 2, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
    push("lui/W", 4, 0, 0, 1, 0, 1, -1, 0, 3, -1, -1, -1);
    drain();
    set(6'b000000, 6'b100011, 1'b0);
    fetch("subu"); decode_go("subu");
    push("subu/E", 2, 0, 0, 0, 0, 0, 0, -1, -1, 1, -1, -1);
    push("subu/W", 4, 0, 0, 1, 0, 1, -1, 1, 0, -1, -1, -1);
    drain();

    // illegal encodings: 2-cycle nop
    set(6'b111111, 6'b000000, 1'b0);
    fetch("ill");
    push("ill/D", 1, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1);
    drain();
    set(6'b000000, 6'b000000, 1'b0);
    fetch("illr");
    push("illr/D", 1, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1);
    drain();

    // reset falls in sw's MEM: write drops the same cycle, count clears
    set(6'b101011, 6'b000000, 1'b0);
    fetch("swr"); decode_go("swr");
    push("swr/E", 2, 0, 0, 0, 0, 0, 1, -1, -1, 0, 1, -1);
    drain();
    reset = 1'b0;
    cnt_m = 0;
    push("swr/rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();
    reset = 1'b1;
    set(6'b000000, 6'b100001, 1'b0);
    fetch("addu2"); decode_go("addu2");
    push("addu2/E", 2, 0, 0, 0, 0, 0, 0, -1, -1, 0, -1, -1);
    push("addu2/W", 4, 0, 0, 1, 0, 1, -1, 1, 0, -1, -1, -1);
    drain();

    // counter wraps through all-ones back to 0
    set(6'b111111, 6'b111111, 1'b0);
    for (int i = 0; i < 17; i++) begin
      fetch("wrap");
      push("wrap/D", 1, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1);
      drain();
    end
    push("end", 0, 1, 1, 0, 0, 0, -1, -1, -1, -1, -1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
